// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 key matrix scanner.
// Also holds the row priority helper used by the scan FSM.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int KEY_W    = 4;

  // Row 0 has the highest priority.
  function automatic logic [1:0] low_row(
    input logic [NUM_ROWS-1:0] r
  );
    low_row = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--)
      if (r[i]) low_row = 2'(i);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider that strobes tick once every DIV cycles.
// Shared with the display multiplex strobe.
module scan_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk0,
  input  logic rst,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] div_q;

  assign tick = (div_q == LAST);

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst)
      div_q <= '0;
    else if (tick)
      div_q <= '0;
    else
      div_q <= div_q + 1'b1;
  end

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 key matrix scanner with press/release debounce.
// Emits a key code plus a one-cycle valid strobe per accepted press.
module key_matrix_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_COUNT = 8
) (
  input  logic             clk0,
  input  logic             rst,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);

  localparam int CW = $clog2(DEB_COUNT + 1);
  localparam logic [CW-1:0] DEB_MAX  = CW'(DEB_COUNT);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_COUNT - 1);

  logic [3:0]       row_m, row_s;
  logic             tick, hit;
  state_t           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       rsel_q, rsel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;

  scan_tick_gen #(
    .DIV (SCAN_DIV)
  ) u_tick (
    .clk0 (clk0),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      row_m <= '0;
      row_s <= '0;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  assign hit = row_s[rsel_q];

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      state_q <= SCAN;
      col_q   <= '0;
      rsel_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      rsel_q  <= rsel_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    rsel_d  = rsel_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (row_s == '0) begin
            col_d = col_q + 1'b1;
          end else begin
            rsel_d  = low_row(row_s);
            cnt_d   = CW'(1);
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (hit && cnt_q == DEB_MAX) begin
            code_d  = {col_q, rsel_q};
            valid_d = 1'b1;
            held_d  = 1'b1;
            cnt_d   = '0;
            state_d = HELD;
          end else if (hit) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d   = '0;
            col_d   = col_q + 1'b1;
            state_d = SCAN;
          end
        end
        HELD: begin
          // Any high sample restarts the release count.
          if (hit) begin
            cnt_d = '0;
          end else if (cnt_q == DEB_LAST) begin
            held_d  = 1'b0;
            cnt_d   = '0;
            col_d   = col_q + 1'b1;
            state_d = SCAN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  assign col       = 4'b0001 << col_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Randomised and directed bench for key_matrix_scan.
// A tick-level key model feeds a scoreboard checked on key_valid.
module tb_key_matrix_scan;

  localparam int DIV = 4;
  localparam int DEB = 3;

  logic       clk0 = 1'b0;
  logic       rst  = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed = '0;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];

  // model state
  int         mode;
  int         mcol;
  int         mrow;
  int         run_n;
  logic [3:0] mcode;
  logic       mheld;
  logic [3:0] m_m, m_s;
  int         ecnt;

  always #5 clk0 = ~clk0;

  // physical matrix: a pressed key shorts its column to its row
  always_comb begin
    row = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (col[c] && pressed[c*4+r]) row[r] = 1'b1;
  end

  key_matrix_scan #(
    .SCAN_DIV  (DIV),
    .DEB_COUNT (DEB)
  ) dut (
    .clk0      (clk0),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  task automatic chk(input logic [3:0] act,
                     input logic [3:0] exp,
                     input string name);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode  = 0;
    mcol  = 0;
    mrow  = 0;
    run_n = 0;
    mcode = '0;
    mheld = 1'b0;
    m_m   = '0;
    m_s   = '0;
    ecnt  = 0;
  endtask

  // Called at a negedge: check, then advance the model across
  // the next posedge, then wait for the following negedge.
  task automatic step();
    logic [3:0] rnow;
    logic [3:0] rs;
    chk(col, 4'(1 << mcol), "col");
    chk({3'b0, key_held}, {3'b0, mheld}, "key_held");
    chk(key_code, mcode, "key_code");
    rnow = '0;
    for (int r = 0; r < 4; r++) rnow[r] = pressed[mcol*4+r];
    rs = m_s;
    if (ecnt % DIV == DIV - 1) begin
      case (mode)
        0: begin
          if (rs == 0) begin
            mcol = (mcol + 1) % 4;
          end else begin
            mrow = 0;
            while (!rs[mrow]) mrow++;
            run_n = 1;
            mode = 1;
          end
        end
        1: begin
          if (rs[mrow]) begin
            run_n++;
            if (run_n == DEB + 1) begin
              mcode = 4'(mcol * 4 + mrow);
              mheld = 1'b1;
              exp_q.push_back(mcode);
              run_n = 0;
              mode = 2;
            end
          end else begin
            run_n = 0;
            mode = 0;
            mcol = (mcol + 1) % 4;
          end
        end
        default: begin
          if (rs[mrow]) begin
            run_n = 0;
          end else begin
            run_n++;
            if (run_n == DEB) begin
              mheld = 1'b0;
              run_n = 0;
              mode = 0;
              mcol = (mcol + 1) % 4;
            end
          end
        end
      endcase
    end
    m_s = m_m;
    m_m = rnow;
    ecnt++;
    @(negedge clk0);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic mid_reset();
    @(posedge clk0);
    #2 rst = 1'b1;
    #1;
    chk(col, 4'b0001, "rst_col");
    chk(key_code, 4'h0, "rst_code");
    chk({3'b0, key_held}, 4'h0, "rst_held");
    chk({3'b0, key_valid}, 4'h0, "rst_valid");
    @(negedge clk0);
    @(negedge clk0);
    rst = 1'b0;
    model_reset();
  endtask

  // scoreboard monitor
  logic prev_valid = 1'b0;
  always @(negedge clk0) begin
    if (!rst && key_valid) begin
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL valid_width two-cycle pulse t=%0t", $time);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected key_code=%h expected=none t=%0t",
                 key_code, $time);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (key_code !== e || key_held !== 1'b1) begin
          errors++;
          $display("FAIL sb_key actual=%h/%b expected=%h/1 t=%0t",
                   key_code, key_held, e, $time);
        end
      end
    end
    prev_valid = rst ? 1'b0 : key_valid;
  end

  initial begin
    model_reset();
    pressed = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk0);
    rst = 1'b0;

    // idle scanning
    run(40);
    mid_reset();
    run(20);

    // key col2,row2
    pressed[2*4+2] = 1'b1;
    run(4 * 14);
    chk(key_code, 4'b1010, "t2_code");
    chk({3'b0, key_held}, 4'h1, "t2_held");
    pressed = '0;
    run(4 * 8);

    // bounce on col0,row1
    pressed[0*4+1] = 1'b1;
    run(4);
    pressed = '0;
    run(4);
    pressed[0*4+1] = 1'b1;
    run(4);
    pressed = '0;
    run(4 * 6);

    // two rows in col3, then a col0 key while held
    pressed[3*4+3] = 1'b1;
    pressed[3*4+1] = 1'b1;
    run(4 * 14);
    chk(key_code, 4'b1101, "t4_code");
    pressed[0*4+0] = 1'b1;
    run(4 * 8);
    pressed[3*4+3] = 1'b0;
    pressed[3*4+1] = 1'b0;
    run(4 * 14);
    pressed = '0;
    run(4 * 8);

    // release bounce
    pressed[1*4+3] = 1'b1;
    run(4 * 14);
    pressed = '0;
    run(8);
    pressed[1*4+3] = 1'b1;
    run(4);
    pressed = '0;
    run(4 * 6);

    // press one cycle before a tick
    while (ecnt % DIV != DIV - 2) step();
    pressed[$urandom_range(0, 15)] = 1'b1;
    run(4 * 12);
    pressed = '0;
    run(4 * 8);

    // reset while a key is held
    pressed[2*4+0] = 1'b1;
    run(4 * 14);
    mid_reset();
    run(4 * 10);
    pressed = '0;
    run(4 * 8);

    // random presses
    for (int i = 0; i < 30; i++) begin
      pressed = '0;
      pressed[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 2) == 0)
        pressed[$urandom_range(0, 15)] = 1'b1;
      run($urandom_range(2, 70));
      pressed = '0;
      run($urandom_range(2, 60));
    end
    run(4 * 10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_pending actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
